// File: rtl/alert_tx_array.sv
// Multi-channel differential alert sender with four-phase handshake, request coalescing and pause.
// Optional ALERT_TX_ACK_SYNC_EN: 2-flop synchroniser on each acknowledge pair.
//
// state    | meaning
// ST_IDLE  | no alert in flight, pair idles at {0,1}
// ST_HS1   | alert raised {1,0}, waiting for ack {1,0}
// ST_HS2   | alert lowered {0,1}, waiting for ack release {0,1}
// ST_PAUSE | minimum gap before the next alert
package pr_pkg;
    typedef struct packed {
        logic alert_p;
        logic alert_n;
    } alert_tx_t;

    typedef struct packed {
        logic ack_p;
        logic ack_n;
    } alert_rx_t;
endpackage

module alert_tx_array #(
    parameter int NumAlerts   = 3,
    parameter int PauseCycles = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic               [NumAlerts-1:0]  alert_req_i,
    input  pr_pkg::alert_rx_t  [NumAlerts-1:0]  alert_rx_i,
    output pr_pkg::alert_tx_t  [NumAlerts-1:0]  alert_tx_o,
    output logic               [NumAlerts-1:0]  busy_o,
    output logic               [NumAlerts-1:0]  integ_fail_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HS1   = 2'd1,
        ST_HS2   = 2'd2,
        ST_PAUSE = 2'd3
    } state_e;

    localparam logic [3:0] PauseLoad = 4'(PauseCycles - 1);

    if (PauseCycles < 1 || PauseCycles > 15) begin : g_pause_chk
        $error("alert_tx_array: PauseCycles must be within 1..15");
    end
    if (NumAlerts < 1 || NumAlerts > 32) begin : g_num_chk
        $error("alert_tx_array: NumAlerts must be within 1..32");
    end

    for (genvar gi = 0; gi < NumAlerts; gi++) begin : g_ch
        pr_pkg::alert_rx_t w_ack;
        state_e            r_state;
        state_e            w_state_nxt;
        logic              r_pending;
        logic              w_pending_nxt;
        logic [3:0]        r_cnt;
        logic [3:0]        w_cnt_nxt;
        logic              r_alert_p;
        logic              r_alert_n;
        logic              r_busy;
        logic              r_integ;
        logic              w_req;
        logic              w_ack_hi;
        logic              w_ack_lo;
        logic              w_integ_err;

`ifdef ALERT_TX_ACK_SYNC_EN
        pr_pkg::alert_rx_t r_sync1;
        pr_pkg::alert_rx_t r_sync2;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_sync1 <= 2'b01;
                r_sync2 <= 2'b01;
            end else begin
                r_sync1 <= alert_rx_i[gi];
                r_sync2 <= r_sync1;
            end
        end

        assign w_ack = r_sync2;
`else
        assign w_ack = alert_rx_i[gi];
`endif

        // Equal rails are a broken pair: flagged, and never accepted as an ack.
        assign w_ack_hi    = w_ack.ack_p & ~w_ack.ack_n;
        assign w_ack_lo    = ~w_ack.ack_p & w_ack.ack_n;
        assign w_integ_err = ~(w_ack.ack_p ^ w_ack.ack_n);
        assign w_req       = r_pending | alert_req_i[gi];

        always_comb begin
            w_state_nxt   = r_state;
            w_cnt_nxt     = r_cnt;
            w_pending_nxt = r_pending | alert_req_i[gi];
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        w_state_nxt   = ST_HS1;
                        w_pending_nxt = 1'b0;
                    end
                end
                ST_HS1: begin
                    if (w_ack_hi) begin
                        w_state_nxt = ST_HS2;
                    end
                end
                ST_HS2: begin
                    if (w_ack_lo) begin
                        w_state_nxt = ST_PAUSE;
                        w_cnt_nxt   = PauseLoad;
                    end
                end
                ST_PAUSE: begin
                    // A coalesced request leaves Pause straight into Hs1 so no cycle is spent in Idle.
                    if (r_cnt == 4'd0) begin
                        if (w_req) begin
                            w_state_nxt   = ST_HS1;
                            w_pending_nxt = 1'b0;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_state   <= ST_IDLE;
                r_pending <= 1'b0;
                r_cnt     <= 4'd0;
                r_alert_p <= 1'b0;
                r_alert_n <= 1'b1;
                r_busy    <= 1'b0;
                r_integ   <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_pending <= w_pending_nxt;
                r_cnt     <= w_cnt_nxt;
                r_alert_p <= (w_state_nxt == ST_HS1);
                r_alert_n <= (w_state_nxt != ST_HS1);
                r_busy    <= (w_state_nxt != ST_IDLE);
                r_integ   <= w_integ_err;
            end
        end

        assign alert_tx_o[gi].alert_p = r_alert_p;
        assign alert_tx_o[gi].alert_n = r_alert_n;
        assign busy_o[gi]             = r_busy;
        assign integ_fail_o[gi]       = r_integ;
    end

endmodule

// File: tb/tb_alert_tx_array.sv
// Self-checking bench for alert_tx_array: directed handshake scenarios plus random traffic vs. a reference model.
`timescale 1ns/1ps
module tb_alert_tx_array;
    localparam int N = 8;
    localparam int P = 2;
`ifdef ALERT_TX_ACK_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic              [N-1:0]   req;
    pr_pkg::alert_rx_t [N-1:0]   ack;
    pr_pkg::alert_tx_t [N-1:0]   tx;
    logic              [N-1:0]   busy;
    logic              [N-1:0]   integ;

    always #5 clk = ~clk;

    alert_tx_array #(.NumAlerts(N), .PauseCycles(P)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .alert_req_i  (req),
        .alert_rx_i   (ack),
        .alert_tx_o   (tx),
        .busy_o       (busy),
        .integ_fail_o (integ)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase 0 idle, 1 alert raised, 2 waiting release, 3 pausing.
    int            ph[N];
    int            left[N];
    bit            pend[N];
    bit            m_integ[N];
    logic [2*N-1:0] d1, d2;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            ph[i] = 0; left[i] = 0; pend[i] = 0; m_integ[i] = 0;
        end
        d1 = {N{2'b01}};
        d2 = {N{2'b01}};
    endtask

    task automatic model_update();
        logic [2*N-1:0] eff;
        logic p, n;
        bit r;
        eff = (LAT == 2) ? d2 : ack;
        d2 = d1;
        d1 = ack;
        for (int i = 0; i < N; i++) begin
            p = eff[2*i+1];
            n = eff[2*i];
            r = req[i] | pend[i];
            m_integ[i] = (p == n);
            pend[i] = r;
            case (ph[i])
                0: if (r) begin ph[i] = 1; pend[i] = 0; end
                1: if (p && !n) ph[i] = 2;
                2: if (!p && n) begin ph[i] = 3; left[i] = P; end
                default: begin
                    left[i] = left[i] - 1;
                    if (left[i] == 0) begin
                        if (r) begin ph[i] = 1; pend[i] = 0; end
                        else ph[i] = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic check(string tag);
        logic [2*N-1:0] etx;
        logic [N-1:0]   eb, ei;
        for (int i = 0; i < N; i++) begin
            etx[2*i+1] = (ph[i] == 1);
            etx[2*i]   = (ph[i] != 1);
            eb[i]      = (ph[i] != 0);
            ei[i]      = m_integ[i];
        end
        n_checks++;
        assert (tx === etx) else begin
            n_fail++;
            $error("FAIL %s_tx observed=%h expected=%h", tag, tx, etx);
        end
        n_checks++;
        assert (busy === eb) else begin
            n_fail++;
            $error("FAIL %s_busy observed=%h expected=%h", tag, busy, eb);
        end
        n_checks++;
        assert (integ === ei) else begin
            n_fail++;
            $error("FAIL %s_integ observed=%h expected=%h", tag, integ, ei);
        end
    endtask

    task automatic chk_int(string tag, int obs, int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(string tag);
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_update();
        #1;
        check(tag);
    endtask

    function automatic pr_pkg::alert_rx_t mirror(int i);
        return (ph[i] == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic settle();
        req = '0;
        for (int c = 0; c < 30; c++) begin
            for (int i = 0; i < N; i++) ack[i] = mirror(i);
            step("settle");
        end
        for (int i = 0; i < N; i++) ack[i] = 2'b01;
    endtask

    initial begin
        int hs2_k, idle_k, rises, second_k, integ_cnt, ch0_done, rnd;
        bit prev_p;

        req = '0;
        for (int i = 0; i < N; i++) ack[i] = 2'b01;
        model_reset();
        repeat (3) step("reset");
        rst_n = 1'b1;

        // Single pulse on channel 0
        hs2_k = -1; idle_k = -1;
        req[0] = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step("single");
            req[0] = 1'b0;
            if (k == 3) ack[0] = 2'b10;
            if (k == 5) ack[0] = 2'b01;
            if (hs2_k < 0 && tx[0] === 2'b01) hs2_k = k;
            if (idle_k < 0 && k > 1 && busy[0] === 1'b0) idle_k = k;
        end
        chk_int("single_hs2_cycle", hs2_k, 4 + LAT);
        chk_int("single_idle_cycle", idle_k, 8 + LAT);

        // Asynchronous reset while channel 1 is in Hs1
        req[1] = 1'b1;
        step("rst_pre");
        req[1] = 1'b0;
        step("rst_pre");
        chk_int("rst_pre_tx1", int'(tx[1]), 2);
        rst_n = 1'b0;
        #1;
        chk_int("rst_async_tx1", int'(tx[1]), 1);
        chk_int("rst_async_busy", int'(busy), 0);
        model_reset();
        repeat (2) step("rst_hold");
        rst_n = 1'b1;
        repeat (5) step("rst_post");
        chk_int("rst_post_busy1", int'(busy[1]), 0);

        // Coalescing on channel 2
        rises = 0; second_k = -1; prev_p = 1'b0;
        req[2] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step("coal");
            req[2] = 1'b0;
            if (k == 1 || k == 2 || k == 7 + LAT) req[2] = 1'b1;
            if (k == 4) ack[2] = 2'b10;
            if (k == 6) ack[2] = 2'b01;
            if (k >= 10 + LAT) ack[2] = mirror(2);
            if (tx[2].alert_p && !prev_p) begin
                rises++;
                if (rises == 2) second_k = k;
            end
            prev_p = tx[2].alert_p;
        end
        chk_int("coal_handshakes", rises, 2);
        chk_int("coal_restart_cycle", second_k, 9 + LAT);
        settle();

        // Integrity failure on channel 0 during Hs1
        integ_cnt = 0; hs2_k = -1;
        req[0] = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step("integ");
            req[0] = 1'b0;
            if (k >= 2 && k <= 4) ack[0] = 2'b11;
            if (k == 5) ack[0] = 2'b10;
            if (k == 7) ack[0] = 2'b01;
            if (k >= 12) ack[0] = mirror(0);
            if (integ[0]) integ_cnt++;
            if (hs2_k < 0 && tx[0] === 2'b01) hs2_k = k;
        end
        chk_int("integ_cycles", integ_cnt, 3);
        chk_int("integ_hs2_cycle", hs2_k, 6 + LAT);
        settle();

        // Independence of channels 0 and 7
        ch0_done = -1;
        req[0] = 1'b1; req[7] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step("indep");
            req = '0;
            ack[0] = mirror(0);
            if (k == 10) ack[7] = 2'b10;
            if (k == 12) ack[7] = 2'b01;
            if (k >= 14) ack[7] = mirror(7);
            if (ch0_done < 0 && k > 1 && busy[0] === 1'b0) begin
                ch0_done = k;
                chk_int("indep_ch7_busy", int'(busy[7]), 1);
            end
        end
        chk_int("indep_ch0_done", ch0_done, 5 + 2 * LAT);
        settle();

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                req[i] = ($urandom_range(0, 7) == 0);
                rnd = $urandom_range(0, 15);
                if (rnd == 0) ack[i] = 2'b00;
                else if (rnd == 1) ack[i] = 2'b11;
                else if (rnd < 9) ack[i] = mirror(i);
            end
            step("rand");
        end
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alert_tx_array.md
# alert_tx_array

Parametrised multi-channel alert sender that drives a vector of `pr_pkg::alert_tx_t` differential pairs to the alert handler. Each channel runs an independent four-phase handshake against a matching `pr_pkg::alert_rx_t` acknowledge pair, coalesces repeated requests, enforces a minimum pause between alerts and flags differential-integrity failures on the acknowledge path. It replaces fixed-width, stateless `alert_tx_t` output ports in peripheral top levels.

## Interface
- `NumAlerts`, 3: number of independent alert channels (1..32).
- `PauseCycles`, 2: idle cycles enforced after each completed handshake (1..15).
- `clk_i` input 1: clock. The block has one clock.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `alert_req_i` input NumAlerts: per-channel alert request, level or pulse, sampled every cycle.
- `alert_rx_i` input `pr_pkg::alert_rx_t [NumAlerts-1:0]`: acknowledge pairs `{ack_p, ack_n}`.
- `alert_tx_o` output `pr_pkg::alert_tx_t [NumAlerts-1:0]`: differential alert pairs `{alert_p, alert_n}`, driven directly from flops.
- `busy_o` output NumAlerts: channel is not in Idle.
- `integ_fail_o` output NumAlerts: registered, one cycle per detected acknowledge-pair error.

## Operation
- Per channel: a sticky `pending` flop, a 4-bit pause counter and an FSM with states Idle, Hs1, Hs2, Pause.
- `pending` is set by `alert_req_i`=1 in any state and cleared on the Idle->Hs1 transition. Requests arriving during Hs1, Hs2 or Pause therefore coalesce into one further alert.
- Idle: `alert_tx_o` = {p=0, n=1}. Go to Hs1 when `pending` is set or `alert_req_i`=1.
- Hs1: `alert_tx_o` = {1,0}. Go to Hs2 when the acknowledge pair is {1,0}.
- Hs2: `alert_tx_o` = {0,1}. Go to Pause when the acknowledge pair is {0,1}. Load the counter with `PauseCycles-1`.
- Pause: `alert_tx_o` = {0,1}. Decrement the counter. Go to Idle when the counter reaches 0.
- Integrity check, in any state: an acknowledge pair of {0,0} or {1,1} pulses `integ_fail_o` for every cycle it is present. The FSM treats such a pair as "no ack" and holds its state.
- Channels are fully independent. No arbitration between channels.
- `NumAlerts`=1 is legal. Counter width is fixed at 4 bits, and `PauseCycles` outside 1..15 is an elaboration error.
- Reset, including mid-handshake: all channels go to Idle with `pending`=0, counter=0, `alert_tx_o`={0,1}, `busy_o`=0 and `integ_fail_o`=0, asynchronously.

## Timing
- `alert_req_i` high in cycle t gives `alert_tx_o` {1,0} from cycle t+1. This is one cycle of latency.
- The acknowledge pair is used as seen at the clock edge, after optional synchronisation (see Configuration).
- Ack {1,0} first sampled at edge k gives `alert_tx_o` {0,1} from cycle k+1.
- Ack {0,1} sampled at edge m gives Pause from m+1, lasting exactly `PauseCycles` cycles. The earliest next Hs1 is m+1+`PauseCycles`.
- Request and ack-release arriving in the same cycle as Hs2: the request is latched in `pending` and the alert is re-issued after Pause. It is never lost.
- `integ_fail_o` asserts on the cycle after the bad pair is sampled.
- `busy_o` equals (state != Idle) and is registered with the state.

## Configuration
- `ALERT_TX_ACK_SYNC_EN` defined: each `ack_p`/`ack_n` passes through a 2-flop synchroniser, reset to {0,1}, before the FSM and the integrity check. This adds 2 cycles to every ack-dependent transition and to `integ_fail_o`.
- `ALERT_TX_ACK_SYNC_EN` undefined: acks are used directly, for a synchronous receiver in the same clock domain.

## Test plan
- Reset mid-Hs1 on channel 1: assert `rst_ni`=0 while `alert_tx_o[1]`={1,0}. Outputs must return to {0,1} immediately, without waiting for a clock edge. After release, channel 1 must stay Idle with no request.
- Single pulse on channel 0, no sync, PauseCycles=2: pulse `alert_req_i[0]` at t0 and respond with ack {1,0} at t0+3 and {0,1} at t0+5. `alert_tx_o[0]` must be {1,0} during t0+1..t0+3 and {0,1} from t0+4. `busy_o[0]` must fall at t0+8.
- Coalescing: pulse `alert_req_i[2]` three times during Hs1 and Pause. Exactly one extra handshake must follow, starting right after Pause.
- Integrity failure: drive ack {1,1} on channel 0 for 3 cycles during Hs1. `integ_fail_o[0]` must be high for 3 cycles, and the state must stay Hs1 until a valid {1,0} arrives.
- Independence with NumAlerts=8: simultaneous requests on channels 0 and 7, with channel 7 acked 10 cycles later. Channel 0 must complete unaffected.
- With `ALERT_TX_ACK_SYNC_EN`: repeat the single-pulse scenario. Hs1->Hs2 and Hs2->Pause must each occur 2 cycles later than in the no-sync case.
